imem_loader: RTL and testbench

//   Writer side of the instruction memory. Receives a program image as a byte

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader itself uses the master modport; the stream source / memory side uses slave.
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory as
// big-endian 32-bit words and keeps the CPU in reset until the image verifies.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_rst_hold,
    output logic          done,
    output logic          err
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHK    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // One extra bit so a count of DEPTH words is representable.
    localparam int CNT_W = ADDR_W + 1;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              byte_ready;
    logic              accept;
    logic [15:0]       new_len;
    logic              last_word;

    assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHK);
    assign accept     = bus.byte_valid && byte_ready;
    assign last_word  = (({{(15-ADDR_W){1'b0}}, word_cnt_q} + 16'd1) == len_q);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        new_len    = {len_q[15:8], bus.byte_data};

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    xor_d      = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {bus.byte_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = new_len;
                    if (new_len > 16'(DEPTH))
                        state_d = S_ERR;
                    else if (new_len == 16'd0)
                        state_d = S_CHK;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d      = xor_q ^ bus.byte_data;
                    asm_d      = {asm_q[15:0], bus.byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte completes the word: issue the write next cycle.
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {asm_q, bus.byte_data};
                        waddr_d    = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (last_word)
                            state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (accept)
                    state_d = (bus.byte_data == xor_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign done           = (state_q == S_DONE);
    assign err            = (state_q == S_ERR);
    assign cpu_rst_hold   = (state_q != S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: literal and table-driven loads plus randomized images,
// checked against a byte-queue model of the stream format.
module tb_imem_loader;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst_hold, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst_hold (cpu_rst_hold),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]        data_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    // Write port observed mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            wa_q.push_back(bus.imem_waddr);
            wd_q.push_back(bus.imem_wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] model_word(input int i);
        return (32'(data_q[4*i]) << 24) | (32'(data_q[4*i+1]) << 16) |
               (32'(data_q[4*i+2]) << 8) | 32'(data_q[4*i+3]);
    endfunction

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'h00;
        foreach (data_q[i]) x ^= data_q[i];
        return x;
    endfunction

    task automatic fill_random(input int nbytes);
        data_q.delete();
        for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rnd && $urandom_range(0, 1) == 0) begin
                bus.byte_valid = 1'b0;
                continue;
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = b;
            if (bus.byte_ready) begin
                @(posedge clk);
                #1 bus.byte_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        bus.byte_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept timeout actual=no_ready required=ready");
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int nw);
        chk({tag, " write_count"}, 32'(wa_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            chk($sformatf("%s waddr[%0d]", tag, i), 32'(wa_q[i]), 32'(i));
            chk($sformatf("%s wdata[%0d]", tag, i), wd_q[i], model_word(i));
        end
    endtask

    // Full load: start, length, data_q (when length is legal), checksum byte.
    task automatic do_load(input string tag, input logic [15:0] len, input logic [7:0] chk_byte,
                           input bit rnd, input bit exp_done, input bit exp_err);
        bit ok;
        int nw;
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(len[15:8], rnd, ok); if (!ok) return;
        send_byte(len[7:0], rnd, ok);  if (!ok) return;
        nw = (int'(len) > DEPTH) ? 0 : int'(len);
        if (int'(len) > DEPTH) begin
            repeat (2) @(negedge clk);
            chk({tag, " ready_in_err"}, 32'(bus.byte_ready), 32'd0);
        end else begin
            for (int i = 0; i < 4 * nw; i++) begin
                send_byte(data_q[i], rnd, ok);
                if (!ok) return;
            end
            @(negedge clk);
            chk({tag, " hold_before_chk"}, 32'(cpu_rst_hold), 32'd1);
            send_byte(chk_byte, rnd, ok); if (!ok) return;
            chk({tag, " hold_after_chk"}, 32'(cpu_rst_hold), 32'(!exp_done));
            repeat (2) @(negedge clk);
        end
        chk({tag, " done"}, 32'(done), 32'(exp_done));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " hold"}, 32'(cpu_rst_hold), 32'(!exp_done));
        check_writes(tag, nw);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " byte_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, " imem_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, " imem_waddr"}, 32'(bus.imem_waddr), 32'd0);
        chk({tag, " imem_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, " cpu_rst_hold"}, 32'(cpu_rst_hold), 32'd1);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
    endtask

    typedef struct {
        logic [15:0] len;
        logic [7:0]  flip;
        bit          rnd;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit ok;
        tbl[0] = '{16'd2,   8'h00, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{16'd2,   8'h01, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'd0,   8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'd0,   8'h01, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{16'h0101, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{16'd256, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{16'd1,   8'h00, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{16'd255, 8'h80, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Literal image; its data bytes XOR to 0x55.
        data_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        do_load("lit_ok", 16'd2, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("lit_ok word0", (wd_q.size() > 0) ? wd_q[0] : 32'hx, 32'h2008_0005);
        chk("lit_ok word1", (wd_q.size() > 1) ? wd_q[1] : 32'hx, 32'h0109_5020);

        // Restart from DONE: loader takes bytes and the CPU is held again.
        pulse_start();
        chk("restart ready", 32'(bus.byte_ready), 32'd1);
        chk("restart hold", 32'(cpu_rst_hold), 32'd1);
        chk("restart done", 32'(done), 32'd0);
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        @(negedge clk);
        chk("restart empty done", 32'(done), 32'd1);

        data_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        do_load("lit_bad", 16'd2, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            fill_random((int'(tbl[t].len) > DEPTH) ? 0 : 4 * int'(tbl[t].len));
            do_load($sformatf("tbl%0d", t), tbl[t].len, model_xor() ^ tbl[t].flip,
                    tbl[t].rnd, tbl[t].exp_done, tbl[t].exp_err);
        end

        for (int t = 0; t < 12; t++) begin
            int   len;
            logic [7:0] flip;
            len  = $urandom_range(1, 24);
            flip = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            fill_random(4 * len);
            do_load($sformatf("rnd%0d", t), 16'(len), model_xor() ^ flip, 1'b1,
                    flip == 8'h00, flip != 8'h00);
        end

        // Asynchronous reset in the middle of word 3 of a 10-word image.
        fill_random(40);
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'd10, 1'b0, ok);
        for (int i = 0; i < 14; i++) send_byte(data_q[i], 1'b0, ok);
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst");
        check_writes("midrst", 3);
        @(negedge clk);
        rst = 1'b0;
        fill_random(12);
        do_load("after_rst", 16'd3, model_xor(), 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
